// File: rtl/missile_ctl.sv
// rtl/missile_ctl.sv - player missile launch, flight and cooldown controller
module missile_ctl #(
  parameter int SPEED     = 8,
  parameter int MISSILE_H = 20,
  parameter int Y_TOP     = 0,
  parameter int COOLDOWN  = 15
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        frame_tick,
  input  logic        fire,
  input  logic [10:0] xpos_ship,
  input  logic [10:0] ypos_ship,
  input  logic        hit,
  input  logic        level_change,
  output logic [10:0] xpos_missile,
  output logic [10:0] ypos_missile,
  output logic        on_missile,
  output logic        shot_fired
);

  // Parked missile sits below every enemy box so it can never collide.
  localparam logic [10:0] Y_PARK = 11'h7FF;
  localparam int          CW     = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
  // One bit wider than y so Y_TOP+SPEED cannot overflow the compare.
  localparam logic [11:0] Y_STEP_MIN = 12'(Y_TOP + SPEED);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    COOL = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [10:0]     x_nxt, y_nxt, y_launch;
  logic            on_nxt, shot_nxt;

  // Launch height clamps at the top of the screen instead of wrapping.
  always_comb begin
    y_launch = 11'd0;
    if (ypos_ship >= 11'(MISSILE_H)) y_launch = ypos_ship - 11'(MISSILE_H);
  end

  // Next-state and next-output logic; level_change overrides everything.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    x_nxt     = 11'd0;
    y_nxt     = Y_PARK;
    on_nxt    = 1'b0;
    shot_nxt  = 1'b0;
    if (level_change) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fire) begin
            state_nxt = FLY;
            x_nxt     = xpos_ship;
            y_nxt     = y_launch;
            on_nxt    = 1'b1;
            shot_nxt  = 1'b1;
          end
        end
        FLY: begin
          x_nxt  = xpos_missile;
          y_nxt  = ypos_missile;
          on_nxt = 1'b1;
          if (hit) begin
            state_nxt = COOL;
            cnt_nxt   = CW'(COOLDOWN);
            x_nxt     = 11'd0;
            y_nxt     = Y_PARK;
            on_nxt    = 1'b0;
          end else if (frame_tick) begin
            if ({1'b0, ypos_missile} >= Y_STEP_MIN) begin
              y_nxt = ypos_missile - 11'(SPEED);
            end else begin
              state_nxt = COOL;
              cnt_nxt   = CW'(COOLDOWN);
              x_nxt     = 11'd0;
              y_nxt     = Y_PARK;
              on_nxt    = 1'b0;
            end
          end
        end
        COOL: begin
          if (cnt == '0)      state_nxt = IDLE;
          else if (frame_tick) cnt_nxt  = cnt - CW'(1);
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, cooldown counter and all outputs are registered together.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      xpos_missile <= 11'd0;
      ypos_missile <= Y_PARK;
      on_missile   <= 1'b0;
      shot_fired   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      xpos_missile <= x_nxt;
      ypos_missile <= y_nxt;
      on_missile   <= on_nxt;
      shot_fired   <= shot_nxt;
    end
  end

endmodule

// File: tb/tb_missile_ctl.sv
// tb/tb_missile_ctl.sv - directed self-checking bench for missile_ctl
module tb_missile_ctl;

  logic        pclk = 1'b0;
  logic        rst;
  logic        frame_tick, fire, hit, level_change;
  logic [10:0] xpos_ship, ypos_ship;
  logic [10:0] xpos_missile, ypos_missile;
  logic        on_missile, shot_fired;
  int          total = 0;
  int          bad   = 0;

  missile_ctl #(.SPEED(8), .MISSILE_H(20), .Y_TOP(0), .COOLDOWN(15)) dut (
    .pclk(pclk), .rst(rst), .frame_tick(frame_tick), .fire(fire),
    .xpos_ship(xpos_ship), .ypos_ship(ypos_ship), .hit(hit),
    .level_change(level_change), .xpos_missile(xpos_missile),
    .ypos_missile(ypos_missile), .on_missile(on_missile), .shot_fired(shot_fired)
  );

  // 100 MHz pixel clock
  always #5 pclk = ~pclk;

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic check_parked(input string tag);
    check({tag, "_x"}, 32'(xpos_missile), 32'd0);
    check({tag, "_y"}, 32'(ypos_missile), 32'h7FF);
    check({tag, "_on"}, 32'(on_missile), 32'd0);
  endtask

  initial begin
    rst = 1'b0; frame_tick = 1'b0; fire = 1'b0; hit = 1'b0; level_change = 1'b0;
    xpos_ship = 11'd400; ypos_ship = 11'd550;
    step(); step();
    check_parked("reset");
    check("reset_shot", 32'(shot_fired), 32'd0);
    rst = 1'b1;
    step(); step();
    check_parked("idle_no_fire");

    // launch from (400,550)
    fire = 1'b1;
    step();
    check("launch_x", 32'(xpos_missile), 32'd400);
    check("launch_y", 32'(ypos_missile), 32'd530);
    check("launch_on", 32'(on_missile), 32'd1);
    check("launch_shot", 32'(shot_fired), 32'd1);
    fire = 1'b0;
    xpos_ship = 11'd100;
    hit = 1'b0;
    step();
    check("shot_one_cycle", 32'(shot_fired), 32'd0);
    check("x_held", 32'(xpos_missile), 32'd400);

    // fly to the top
    for (int i = 0; i < 66; i++) tick();
    check("top_y", 32'(ypos_missile), 32'd2);
    check("top_on", 32'(on_missile), 32'd1);
    tick();
    check_parked("top_end");

    // cooldown with fire held: launch follows the 15th tick
    fire = 1'b1;
    for (int i = 0; i < 14; i++) begin
      tick();
      step();
      check("cool_no_shot", 32'(shot_fired), 32'd0);
    end
    tick();
    check("cool_t15_shot", 32'(shot_fired), 32'd0);
    step();
    check("cool_idle_shot", 32'(shot_fired), 32'd0);
    check("cool_idle_on", 32'(on_missile), 32'd0);
    step();
    check("auto_shot", 32'(shot_fired), 32'd1);
    check("auto_x", 32'(xpos_missile), 32'd100);
    check("auto_y", 32'(ypos_missile), 32'd530);
    step();
    check("auto_shot_once", 32'(shot_fired), 32'd0);
    fire = 1'b0;

    // level_change in flight, relaunch at y=300, then hit with tick
    level_change = 1'b1;
    step();
    level_change = 1'b0;
    check_parked("lc_fly");
    ypos_ship = 11'd320;
    fire = 1'b1;
    step();
    fire = 1'b0;
    check("y300", 32'(ypos_missile), 32'd300);
    hit = 1'b1; frame_tick = 1'b1;
    step();
    hit = 1'b0; frame_tick = 1'b0;
    check_parked("hit_vs_tick");

    // hit while cooling is ignored; level_change at count 10
    for (int i = 0; i < 5; i++) tick();
    hit = 1'b1;
    step();
    hit = 1'b0;
    check_parked("hit_in_cool");
    level_change = 1'b1; fire = 1'b1;
    step();
    level_change = 1'b0;
    check("lc_cool_on", 32'(on_missile), 32'd0);
    check("lc_cool_shot", 32'(shot_fired), 32'd0);
    step();
    check("lc_launch_shot", 32'(shot_fired), 32'd1);
    check("lc_launch_on", 32'(on_missile), 32'd1);
    fire = 1'b0;

    // clamp at top: ypos_ship below MISSILE_H
    level_change = 1'b1;
    step();
    level_change = 1'b0;
    ypos_ship = 11'd5;
    fire = 1'b1;
    step();
    fire = 1'b0;
    check("clamp_y", 32'(ypos_missile), 32'd0);
    check("clamp_on", 32'(on_missile), 32'd1);
    tick();
    check_parked("clamp_end");

    // reset mid-flight at y=200
    level_change = 1'b1;
    step();
    level_change = 1'b0;
    ypos_ship = 11'd220;
    fire = 1'b1;
    step();
    fire = 1'b0;
    check("pre_rst_y", 32'(ypos_missile), 32'd200);
    #2 rst = 1'b0;
    #1;
    check_parked("async_rst");
    check("async_rst_shot", 32'(shot_fired), 32'd0);
    step();
    rst = 1'b1;
    step(); step(); step();
    check_parked("post_rst_idle");
    fire = 1'b1;
    step();
    fire = 1'b0;
    check("post_rst_shot", 32'(shot_fired), 32'd1);
    check("post_rst_y", 32'(ypos_missile), 32'd200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
